// File: rtl/sq_drain.sv
// Store-queue drain FSM: retires committed SQ heads, issuing cache writes or MMIO retires.
// Optional perf counters are enabled by defining SQ_DRAIN_PERF_EN.
`ifndef SRC_RANGE
`define SRC_RANGE 63:0
`endif

module sq_drain #(
  parameter  int SQ_DEPTH = 16,
  localparam int PTR_W    = $clog2(SQ_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              head_valid,
  input  logic              head_ready_to_go,
  input  logic              head_mmio,
  input  logic [`SRC_RANGE] head_store_addr,
  input  logic [`SRC_RANGE] head_store_data,
  input  logic [`SRC_RANGE] head_store_mask,
  input  logic [3:0]        head_store_ls_size,
  output logic              issuing,
  output logic [PTR_W-1:0]  deq_ptr,
  output logic              dcache_req_valid,
  input  logic              dcache_req_ready,
  output logic [`SRC_RANGE] dcache_req_addr,
  output logic [`SRC_RANGE] dcache_req_data,
  output logic [`SRC_RANGE] dcache_req_mask,
  output logic [3:0]        dcache_req_size,
  input  logic              dcache_resp_valid,
  output logic              drain_busy
`ifdef SQ_DRAIN_PERF_EN
  ,
  output logic [63:0]       perf_drain_cnt,
  output logic [63:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;

  typedef struct packed {
    logic [`SRC_RANGE] addr;
    logic [`SRC_RANGE] data;
    logic [`SRC_RANGE] mask;
    logic [3:0]        size;
  } sq_pay_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr_q, ptr_nxt;
  logic             fp_q, fp_nxt;
  logic             latch, issue_c;
  sq_pay_t          pay_q;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr_q;
    fp_nxt    = fp_q;
    latch     = 1'b0;
    issue_c   = 1'b0;
    unique case (state)
      IDLE: begin
        fp_nxt = 1'b0;
        // flush wins over a committed head: nothing starts in the flush cycle
        if (flush) begin
          ptr_nxt = '0;
        end else if (head_valid && head_ready_to_go) begin
          if (head_mmio) begin
            issue_c = 1'b1;
            ptr_nxt = ptr_q + PTR_W'(1);
          end else begin
            latch     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (flush) fp_nxt = 1'b1;
        if (dcache_req_ready) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (flush) fp_nxt = 1'b1;
        if (dcache_resp_valid) begin
          state_nxt = IDLE;
          fp_nxt    = 1'b0;
          // the store still lands in the cache; only the retire is squashed
          if (fp_q || flush) begin
            ptr_nxt = '0;
          end else begin
            issue_c = 1'b1;
            ptr_nxt = ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr_q <= '0;
      fp_q  <= 1'b0;
      pay_q <= '0;
    end else begin
      state <= state_nxt;
      ptr_q <= ptr_nxt;
      fp_q  <= fp_nxt;
      if (latch) pay_q <= '{head_store_addr, head_store_data, head_store_mask, head_store_ls_size};
    end
  end

  // gated so an MMIO head cannot pulse issuing while reset is held
  assign issuing          = issue_c & reset_n;
  assign deq_ptr          = ptr_q;
  assign dcache_req_valid = (state == REQ);
  assign dcache_req_addr  = pay_q.addr;
  assign dcache_req_data  = pay_q.data;
  assign dcache_req_mask  = pay_q.mask;
  assign dcache_req_size  = pay_q.size;
  assign drain_busy       = (state != IDLE);

`ifdef SQ_DRAIN_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_drain_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue_c) perf_drain_cnt <= perf_drain_cnt + 64'd1;
      if (state == REQ && !dcache_req_ready) perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sq_drain.sv
// Randomized scoreboard bench for sq_drain plus directed boundary scenarios.
`ifndef SRC_RANGE
`define SRC_RANGE 63:0
`endif

module tb_sq_drain;
  localparam int D  = 16;
  localparam int PW = $clog2(D) + 1;

  logic clock = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic head_valid = 1'b0, head_ready_to_go = 1'b0, head_mmio = 1'b0;
  logic [`SRC_RANGE] head_store_addr = '0, head_store_data = '0, head_store_mask = '0;
  logic [3:0] head_store_ls_size = '0;
  logic issuing, dcache_req_valid, drain_busy;
  logic [PW-1:0] deq_ptr;
  logic dcache_req_ready = 1'b0, dcache_resp_valid = 1'b0;
  logic [`SRC_RANGE] dcache_req_addr, dcache_req_data, dcache_req_mask;
  logic [3:0] dcache_req_size;
`ifdef SQ_DRAIN_PERF_EN
  logic [63:0] perf_drain_cnt, perf_stall_cnt;
`endif

  sq_drain #(.SQ_DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .head_valid(head_valid), .head_ready_to_go(head_ready_to_go), .head_mmio(head_mmio),
    .head_store_addr(head_store_addr), .head_store_data(head_store_data),
    .head_store_mask(head_store_mask), .head_store_ls_size(head_store_ls_size),
    .issuing(issuing), .deq_ptr(deq_ptr),
    .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
    .dcache_req_addr(dcache_req_addr), .dcache_req_data(dcache_req_data),
    .dcache_req_mask(dcache_req_mask), .dcache_req_size(dcache_req_size),
    .dcache_resp_valid(dcache_resp_valid), .drain_busy(drain_busy)
`ifdef SQ_DRAIN_PERF_EN
    , .perf_drain_cnt(perf_drain_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {logic [63:0] a, d, m; logic [3:0] s;} req_t;
  typedef struct {int ptr; bit mmio;} ret_t;
  req_t req_q[$];
  ret_t ret_q[$];
  int n_chk = 0, n_pass = 0;
  bit sb_on = 1'b0, auto_dc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event did not occur as expected", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_issue(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (issuing) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic do_reset();
    head_ready_to_go = 0; head_mmio = 0; flush = 0;
    dcache_req_ready = 0; dcache_resp_valid = 0;
    reset_n = 0;
    @(negedge clock);
    chk("rst_issuing", issuing, 0);
    chk("rst_reqv", dcache_req_valid, 0);
    chk("rst_busy", drain_busy, 0);
    chk("rst_ptr", deq_ptr, 0);
    @(posedge clock);
    #1 reset_n = 1;
  endtask

  // scoreboard monitor: every accepted request and every retire must match the next expectation
  always @(negedge clock) begin
    req_t r;
    ret_t t;
    if (sb_on && reset_n) begin
      if (dcache_req_valid && dcache_req_ready) begin
        if (req_q.size() == 0) fail_now("sb_req_unexpected");
        else begin
          r = req_q.pop_front();
          chk("sb_addr", dcache_req_addr, r.a);
          chk("sb_data", dcache_req_data, r.d);
          chk("sb_mask", dcache_req_mask, r.m);
          chk("sb_size", {60'b0, dcache_req_size}, {60'b0, r.s});
        end
      end
      if (issuing) begin
        if (ret_q.size() == 0) fail_now("sb_retire_unexpected");
        else begin
          t = ret_q.pop_front();
          chk("sb_ptr", deq_ptr, t.ptr);
          chk("sb_busy", drain_busy, t.mmio ? 0 : 1);
          chk("sb_reqv_on_issue", dcache_req_valid, 0);
        end
      end
    end
  end

  // random dcache: ready/resp noise every cycle, including outside the states that use them
  initial forever begin
    @(posedge clock);
    #1;
    if (auto_dc) begin
      dcache_req_ready  = ($urandom % 2) == 0;
      dcache_resp_valid = ($urandom % 3) == 0;
    end
  end

  initial begin
    #500000;
    fail_now("watchdog");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    int n;
    bit ok;
    bit m;
    req_t r;
    logic [63:0] stall0;
    do_reset();

    // ---- randomized phase ----
    sb_on = 1; auto_dc = 1; n = 0;
    for (int i = 0; i < 60; i++) begin
      head_ready_to_go = 0;
      for (int g = 0; g < int'($urandom % 3); g++) begin
        head_valid = $urandom % 2;
        head_mmio  = $urandom % 2;
        @(negedge clock);
        chk("idle_no_issue", issuing, 0);
        chk("idle_not_busy", drain_busy, 0);
        tick();
      end
      m = $urandom % 2;
      r.a = {$urandom, $urandom}; r.d = {$urandom, $urandom};
      r.m = {$urandom, $urandom}; r.s = 4'($urandom);
      head_mmio = m; head_store_addr = r.a; head_store_data = r.d;
      head_store_mask = r.m; head_store_ls_size = r.s;
      if (!m) req_q.push_back(r);
      ret_q.push_back('{n % (2 * D), m});
      n++;
      head_valid = 1; head_ready_to_go = 1;
      wait_issue("rand_timeout", ok);
      tick();
      if (!ok) break;
    end
    head_ready_to_go = 0;
    auto_dc = 0; dcache_req_ready = 0; dcache_resp_valid = 0;
    @(negedge clock);
    sb_on = 0;
    chk("sb_drained", req_q.size() + ret_q.size(), 0);
    chk("rand_ptr", deq_ptr, n % (2 * D));

    // ---- basic cache store, immediate ready/resp ----
    do_reset();
    dcache_req_ready = 1; dcache_resp_valid = 1;
    head_mmio = 0; head_store_addr = 64'h8000_0010; head_store_data = 64'hDEAD_BEEF;
    head_store_mask = 64'hFF; head_store_ls_size = 4'd8;
    head_valid = 1; head_ready_to_go = 1;
    @(negedge clock);
    chk("t21_c1_reqv", dcache_req_valid, 0);
    chk("t21_c1_iss", issuing, 0);
    tick();
    @(negedge clock);
    chk("t21_c2_reqv", dcache_req_valid, 1);
    chk("t21_addr", dcache_req_addr, 64'h8000_0010);
    chk("t21_data", dcache_req_data, 64'hDEAD_BEEF);
    chk("t21_mask", dcache_req_mask, 64'hFF);
    chk("t21_size", {60'b0, dcache_req_size}, 64'd8);
    chk("t21_c2_iss", issuing, 0);
    tick();
    @(negedge clock);
    chk("t21_c3_iss", issuing, 1);
    chk("t21_c3_reqv", dcache_req_valid, 0);
    chk("t21_c3_ptr", deq_ptr, 0);
    tick();
    head_ready_to_go = 0;
    @(negedge clock);
    chk("t21_ptr", deq_ptr, 1);
    chk("t21_idle_resp_ignored", issuing, 0);
    chk("t21_idle", drain_busy, 0);
`ifdef SQ_DRAIN_PERF_EN
    chk("t21_perf_drain", perf_drain_cnt, 1);
    stall0 = perf_stall_cnt;
`else
    stall0 = 0;
`endif
    tick();

    // ---- backpressure: ready low 5 cycles ----
    dcache_req_ready = 0; dcache_resp_valid = 0;
    head_store_addr = 64'h1234_5678_9ABC_DEF0; head_store_data = 64'h0F0F_0F0F_A5A5_5A5A;
    head_ready_to_go = 1;
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k == 5) dcache_req_ready = 1;
      head_store_addr = {$urandom, $urandom};
      @(negedge clock);
      chk("t22_reqv", dcache_req_valid, 1);
      chk("t22_addr_stable", dcache_req_addr, 64'h1234_5678_9ABC_DEF0);
      chk("t22_data_stable", dcache_req_data, 64'h0F0F_0F0F_A5A5_5A5A);
      tick();
    end
    dcache_req_ready = 0;
    @(negedge clock);
    chk("t22_wait_reqv", dcache_req_valid, 0);
    chk("t22_wait_busy", drain_busy, 1);
`ifdef SQ_DRAIN_PERF_EN
    chk("t22_perf_stall", perf_stall_cnt - stall0, 5);
`else
    stall0 = stall0;
`endif
    tick();
    dcache_resp_valid = 1;
    @(negedge clock);
    chk("t22_iss", issuing, 1);
    tick();
    head_ready_to_go = 0; dcache_resp_valid = 0;
    @(negedge clock);
    chk("t22_ptr", deq_ptr, 2);

    // ---- four back-to-back MMIO ----
    do_reset();
    head_mmio = 1; head_ready_to_go = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t23_iss", issuing, 1);
      chk("t23_reqv", dcache_req_valid, 0);
      chk("t23_ptr", deq_ptr, k);
      tick();
    end
    head_ready_to_go = 0;
    @(negedge clock);
    chk("t23_ptr_end", deq_ptr, 4);
    chk("t23_iss_end", issuing, 0);

    // ---- pointer wrap ----
    do_reset();
    head_mmio = 1; head_ready_to_go = 1;
    repeat (15) tick();
    head_ready_to_go = 0;
    @(negedge clock);
    chk("t24_ptr15", deq_ptr, 15);
    head_mmio = 0; dcache_req_ready = 1; dcache_resp_valid = 1; head_ready_to_go = 1;
    wait_issue("t24_timeout", ok);
    tick();
    head_ready_to_go = 0;
    @(negedge clock);
    chk("t24_ptr16", deq_ptr, 16);
    head_mmio = 1; head_ready_to_go = 1;
    repeat (16) tick();
    head_ready_to_go = 0;
    @(negedge clock);
    chk("t24_ptr_wrap0", deq_ptr, 0);

    // ---- flush during WAIT_RESP ----
    head_mmio = 1; head_ready_to_go = 1; dcache_resp_valid = 0;
    tick();
    head_mmio = 0;
    tick();
    tick();
    flush = 1;
    @(negedge clock);
    chk("t25_busy", drain_busy, 1);
    chk("t25_iss0", issuing, 0);
    tick();
    flush = 0;
    @(negedge clock);
    chk("t25_iss1", issuing, 0);
    tick();
    dcache_resp_valid = 1;
    @(negedge clock);
    chk("t25_iss_suppressed", issuing, 0);
    tick();
    head_ready_to_go = 0; dcache_resp_valid = 0;
    @(negedge clock);
    chk("t25_ptr", deq_ptr, 0);
    chk("t25_idle", drain_busy, 0);

    // ---- flush in IDLE with MMIO head ----
    head_mmio = 1; head_ready_to_go = 1;
    tick();
    flush = 1;
    @(negedge clock);
    chk("t25b_ptr_before", deq_ptr, 1);
    chk("t25b_iss", issuing, 0);
    tick();
    flush = 0; head_ready_to_go = 0;
    @(negedge clock);
    chk("t25b_ptr", deq_ptr, 0);

    // ---- async reset in the middle of REQ ----
    dcache_req_ready = 0; head_ready_to_go = 1;
    tick();
    head_mmio = 0;
    tick();
    @(negedge clock);
    chk("t26_reqv_before", dcache_req_valid, 1);
    #2;
    head_mmio = 1;
    reset_n = 0;
    #1;
    chk("t26_reqv", dcache_req_valid, 0);
    chk("t26_ptr", deq_ptr, 0);
    chk("t26_busy", drain_busy, 0);
    chk("t26_iss", issuing, 0);
    chk("t26_payload", dcache_req_addr, 0);
    head_ready_to_go = 0;
    tick();
    reset_n = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
